// File: rtl/clk_gate_pkg.sv
// Shared types and limits for the automatic clock-gating controller.
package clk_gate_pkg;

  typedef enum logic [1:0] {
    StRun,
    StCount,
    StGated,
    StWake
  } clk_gate_state_e;

  localparam int unsigned WAKE_CYC_MAX = 15;
  localparam int unsigned WCNT_W       = $clog2(WAKE_CYC_MAX + 1);

endpackage

// File: rtl/clk_icg.sv
// Latch-based integrated clock gate: enable captured while clk_i is low, so
// a pulse that has started is never cut short.
module clk_icg (
  input  logic clk_i,
  input  logic en_i,
  input  logic te_i,
  output logic clk_o
);

  logic en_latch;

  always_latch begin
    if (!clk_i) en_latch = en_i | te_i;
  end

  assign clk_o = clk_i & en_latch;

endmodule

// File: rtl/clk_gate_ctrl.sv
// Automatic clock-gating controller: gates after a run of idle cycles and
// reopens on wake with a fixed settling delay before reporting ready.
module clk_gate_ctrl
  import clk_gate_pkg::*;
#(
  parameter int unsigned IDLE_W   = 8,
  parameter int unsigned WAKE_CYC = 2,
  parameter int unsigned STAT_W   = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              te_i,
  input  logic              auto_en_i,
  input  logic              busy_i,
  input  logic              wake_req_i,
  input  logic              force_on_i,
  input  logic [IDLE_W-1:0] idle_thresh_i,
  output logic              clk_o,
  output logic              gate_en_o,
  output logic              clk_rdy_o,
  output logic [STAT_W-1:0] gate_cnt_o
);

  localparam logic [WCNT_W-1:0] WakeLast = WCNT_W'(WAKE_CYC - 1);

  clk_gate_state_e   state_q;
  logic [IDLE_W-1:0] icnt_q;
  logic [WCNT_W-1:0] wcnt_q;
  logic              gate_en_q;
  logic              clk_rdy_q;
  logic [STAT_W-1:0] gate_cnt_q;

  logic              wake;
  logic              idle;
  logic [IDLE_W-1:0] icnt_inc;
  logic [STAT_W-1:0] gate_cnt_inc;

  assign wake     = busy_i | wake_req_i | force_on_i | ~auto_en_i;
  assign idle     = ~busy_i & auto_en_i & ~force_on_i & (idle_thresh_i != '0);
  assign icnt_inc = icnt_q + IDLE_W'(1);
  assign gate_cnt_inc = (gate_cnt_q == '1) ? gate_cnt_q : gate_cnt_q + STAT_W'(1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StRun;
      icnt_q     <= '0;
      wcnt_q     <= '0;
      gate_en_q  <= 1'b1;
      clk_rdy_q  <= 1'b1;
      gate_cnt_q <= '0;
    end else begin
      unique case (state_q)
        StRun, StCount: begin
          if (!idle) begin
            state_q <= StRun;
            icnt_q  <= '0;
          end else if (((state_q == StRun) && (idle_thresh_i == IDLE_W'(1))) ||
                       ((state_q == StCount) && (icnt_inc >= idle_thresh_i))) begin
            // >= so a threshold lowered mid-count gates on the next idle sample
            state_q    <= StGated;
            icnt_q     <= '0;
            gate_en_q  <= 1'b0;
            clk_rdy_q  <= 1'b0;
            gate_cnt_q <= gate_cnt_inc;
          end else begin
            state_q <= StCount;
            icnt_q  <= (state_q == StRun) ? IDLE_W'(1) : icnt_inc;
          end
        end
        StGated: begin
          if (wake) begin
            state_q   <= StWake;
            wcnt_q    <= '0;
            gate_en_q <= 1'b1;
          end
        end
        StWake: begin
          if (wcnt_q == WakeLast) begin
            state_q   <= StRun;
            wcnt_q    <= '0;
            clk_rdy_q <= 1'b1;
          end else begin
            wcnt_q <= wcnt_q + WCNT_W'(1);
          end
        end
        default: state_q <= StRun;
      endcase
    end
  end

  assign gate_en_o  = gate_en_q;
  assign clk_rdy_o  = clk_rdy_q;
  assign gate_cnt_o = gate_cnt_q;

  clk_icg u_icg (
    .clk_i (clk_i),
    .en_i  (gate_en_q),
    .te_i  (te_i),
    .clk_o (clk_o)
  );

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Directed bench for clk_gate_ctrl with a per-cycle behavioural model.
module tb_clk_gate_ctrl;

  localparam int unsigned IDLE_W   = 8;
  localparam int unsigned WAKE_CYC = 2;
  localparam int unsigned STAT_W   = 6;
  localparam int          CNT_MAX  = (1 << STAT_W) - 1;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic              te_i = 1'b0;
  logic              auto_en_i = 1'b1;
  logic              busy_i = 1'b0;
  logic              wake_req_i = 1'b0;
  logic              force_on_i = 1'b0;
  logic [IDLE_W-1:0] idle_thresh_i = 8'd4;
  logic              clk_o;
  logic              gate_en_o;
  logic              clk_rdy_o;
  logic [STAT_W-1:0] gate_cnt_o;

  clk_gate_ctrl #(
    .IDLE_W   (IDLE_W),
    .WAKE_CYC (WAKE_CYC),
    .STAT_W   (STAT_W)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .te_i          (te_i),
    .auto_en_i     (auto_en_i),
    .busy_i        (busy_i),
    .wake_req_i    (wake_req_i),
    .force_on_i    (force_on_i),
    .idle_thresh_i (idle_thresh_i),
    .clk_o         (clk_o),
    .gate_en_o     (gate_en_o),
    .clk_rdy_o     (clk_rdy_o),
    .gate_cnt_o    (gate_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int vectors = 0;
  int miscompares = 0;
  bit check_en = 1'b0;

  // Model: idle run length, gated flag, remaining settle cycles, event count.
  int m_run = 0;
  bit m_gated = 1'b0;
  int m_wake_left = 0;
  int m_cnt = 0;

  always @(posedge clk_i) begin
    automatic int run = m_run;
    automatic bit gated = m_gated;
    automatic int wl = m_wake_left;
    automatic int cnt = m_cnt;
    automatic bit idle = !busy_i && auto_en_i && !force_on_i && (idle_thresh_i != 0);
    automatic bit wake = busy_i || wake_req_i || force_on_i || !auto_en_i;
    if (rst_i) begin
      run = 0; gated = 0; wl = 0; cnt = 0;
    end else if (wl > 0) begin
      wl = wl - 1;
    end else if (gated) begin
      if (wake) begin
        gated = 0;
        wl = WAKE_CYC;
      end
    end else if (idle) begin
      run = run + 1;
      if (run >= int'(idle_thresh_i)) begin
        gated = 1;
        run = 0;
        if (cnt < CNT_MAX) cnt = cnt + 1;
      end
    end else begin
      run = 0;
    end
    m_run <= run;
    m_gated <= gated;
    m_wake_left <= wl;
    m_cnt <= cnt;
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare; clk_o must be low in the low phase and, in the high
  // phase, reflect the enable seen during the preceding low phase.
  initial begin
    bit exp_hi;
    forever begin
      @(negedge clk_i);
      #1;
      if (check_en) begin
        chk("gate_en", int'(gate_en_o), int'(!m_gated));
        chk("clk_rdy", int'(clk_rdy_o), int'(!m_gated && m_wake_left == 0));
        chk("gate_cnt", int'(gate_cnt_o), m_cnt);
        chk("clk_o_low", int'(clk_o), 0);
      end
      exp_hi = !m_gated || te_i;
      @(posedge clk_i);
      #3;
      if (check_en) chk("clk_o_high", int'(clk_o), int'(exp_hi));
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  initial begin
    // Reset with the peripheral idle
    step(2);
    check_en = 1'b1;
    chk("rst_gate_en", int'(gate_en_o), 1);
    chk("rst_clk_rdy", int'(clk_rdy_o), 1);
    chk("rst_gate_cnt", int'(gate_cnt_o), 0);
    busy_i = 1'b1;
    rst_i = 1'b0;
    step(5);

    // Threshold 4: gate_en falls on the 4th idle sample
    busy_i = 1'b0;
    step(3);
    chk("thr4_before", int'(gate_en_o), 1);
    step(1);
    chk("thr4_gated", int'(gate_en_o), 0);
    chk("thr4_cnt", int'(gate_cnt_o), 1);
    step(4);

    // Scan enable keeps clk_o running while gated
    te_i = 1'b1;
    step(4);
    chk("te_gate_en", int'(gate_en_o), 0);
    te_i = 1'b0;
    step(2);

    // One-cycle wake pulse
    wake_req_i = 1'b1;
    step(1);
    wake_req_i = 1'b0;
    busy_i = 1'b1;
    chk("wake_e_en", int'(gate_en_o), 1);
    chk("wake_e_rdy", int'(clk_rdy_o), 0);
    step(1);
    chk("wake_e1_rdy", int'(clk_rdy_o), 0);
    step(1);
    chk("wake_e2_rdy", int'(clk_rdy_o), 1);

    // Idle runs of 3 broken by single busy cycles never gate
    for (int i = 0; i < 5; i++) begin
      busy_i = 1'b0;
      step(3);
      busy_i = 1'b1;
      step(1);
    end
    chk("runs3_en", int'(gate_en_o), 1);
    chk("runs3_cnt", int'(gate_cnt_o), 1);

    // Threshold 0, force_on, auto_en low: no gating
    busy_i = 1'b0;
    idle_thresh_i = 8'd0;
    step(100);
    chk("thr0_en", int'(gate_en_o), 1);
    idle_thresh_i = 8'd4;
    force_on_i = 1'b1;
    step(100);
    chk("force_en", int'(gate_en_o), 1);
    force_on_i = 1'b0;
    auto_en_i = 1'b0;
    step(20);
    chk("noauto_en", int'(gate_en_o), 1);
    auto_en_i = 1'b1;

    // Lowering the threshold mid-count gates at the next idle sample
    idle_thresh_i = 8'd8;
    step(5);
    idle_thresh_i = 8'd2;
    step(1);
    chk("lower_en", int'(gate_en_o), 0);
    chk("lower_cnt", int'(gate_cnt_o), 2);

    // Reset in GATED, then in WAKE
    rst_i = 1'b1;
    step(1);
    chk("rstg_en", int'(gate_en_o), 1);
    chk("rstg_cnt", int'(gate_cnt_o), 0);
    rst_i = 1'b0;
    idle_thresh_i = 8'd1;
    step(1);
    chk("thr1_en", int'(gate_en_o), 0);
    wake_req_i = 1'b1;
    step(1);
    chk("rstw_pre_rdy", int'(clk_rdy_o), 0);
    wake_req_i = 1'b0;
    rst_i = 1'b1;
    step(1);
    chk("rstw_rdy", int'(clk_rdy_o), 1);
    chk("rstw_cnt", int'(gate_cnt_o), 0);
    rst_i = 1'b0;

    // Busy raised in the gating-entry cycle is seen on the following edge
    step(1);
    busy_i = 1'b1;
    step(1);
    chk("late_busy_en", int'(gate_en_o), 1);
    chk("late_busy_rdy", int'(clk_rdy_o), 0);
    step(3);

    // Saturate the gating-event counter
    rst_i = 1'b1;
    step(1);
    rst_i = 1'b0;
    busy_i = 1'b0;
    wake_req_i = 1'b1;
    step(4 * (CNT_MAX + 4));
    chk("sat_cnt", int'(gate_cnt_o), CNT_MAX);
    wake_req_i = 1'b0;
    busy_i = 1'b1;
    step(5);

    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
